pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Consumer end of the hazard interface: takes the CPU hazard requests (data_hazard, PC_hazard, pop_haz, keyboard_hazard) and the PC_Update handshake. Drives the pipeline register write enables, the flush/bubble controls and the PC write enable. Sits between the hazard detector and the PC / IFID / IDEX pipeline registers. Owns the control-transfer wait sequence, which the detector only flags.

Parameters:
CTRL_TIMEOUT, 7, max cycles in CTRL_WAIT without PC_update before abandoning the wait.
FLUSH_CYCLES, 2, cycles IFID is flushed after a redirect (1..3).
CNT_W, 3, width of the internal wait/flush counter; must hold max(CTRL_TIMEOUT, FLUSH_CYCLES).
PERF_W, 16, width of the stall performance counter.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
data_hazard  in  1  load-use stall request
PC_hazard  in  1  control transfer pending (branch/jreg/call/ret)
pop_haz  in  1  stack-pop stall request
keyboard_hazard  in  1  I/O freeze request
PC_update  in  1  one-cycle pulse: PC_Update has the target PC ready
PC_write_en  out  1  PC register load enable
IFID_write_en  out  1  IFID register enable
IFID_flush  out  1  clear IFID to NOP
IDEX_flush  out  1  insert bubble into IDEX
EXMEM_write_en  out  1  EXMEM/MEMWB enable (0 only during I/O freeze)
ctrl_timeout  out  1  sticky error flag: a CTRL_WAIT expired
stall_state  out  3  current FSM state encoding, for debug
stall_cycles  out  PERF_W  saturating count of cycles with PC_write_en=0

Behaviour:
- Reset (async, any state, mid-sequence included):
  - state=RUN, counter=0, ctrl_timeout=0, stall_cycles=0.
  - While rst=1 the outputs are PC_write_en=0, IFID_write_en=0, EXMEM_write_en=0, IFID_flush=1, IDEX_flush=1.
- States: RUN=0, CTRL_WAIT=1, REDIRECT=2, IO_WAIT=3. Outputs are a combinational function of state and inputs (Mealy in RUN, so the response lands in the same cycle).
- RUN, priority order keyboard_hazard > PC_update > PC_hazard > data_hazard > pop_haz:
  - keyboard_hazard=1: all write enables 0, no flushes; next state IO_WAIT.
  - PC_update=1 (with or without PC_hazard): PC_write_en=1, IFID_flush=1; counter loads FLUSH_CYCLES-1; next state REDIRECT, or RUN if FLUSH_CYCLES=1.
  - PC_hazard=1: PC_write_en=0, IFID_write_en=1, IFID_flush=1, IDEX_flush=0; counter=0; next state CTRL_WAIT.
  - data_hazard=1 or pop_haz=1: PC_write_en=0, IFID_write_en=0, IDEX_flush=1; stay in RUN. Each asserted cycle costs exactly one bubble.
  - None asserted: PC_write_en=1, IFID_write_en=1, EXMEM_write_en=1, flushes 0.
- CTRL_WAIT:
  - PC_write_en=0, IFID_flush=1, IDEX_flush=0, EXMEM_write_en=1; the counter increments every cycle.
  - data_hazard, pop_haz and keyboard_hazard are ignored.
  - PC_update=1: same actions as PC_update in RUN; next state REDIRECT.
  - Otherwise, if counter==CTRL_TIMEOUT-1: set ctrl_timeout (held until reset); next state RUN.
- REDIRECT:
  - PC_write_en=1, IFID_flush=1; the counter decrements.
  - At 0 the next state is RUN. Total flush length from the PC_update cycle is FLUSH_CYCLES.
  - A PC_update in REDIRECT reloads the counter (back-to-back redirect).
- IO_WAIT:
  - All write enables 0, flushes 0.
  - Next state RUN on the first cycle with keyboard_hazard=0. No bubble is inserted on exit.
- stall_cycles: increments on every non-reset cycle with PC_write_en=0 and saturates at all-ones (no wrap).
- Unused state encodings go to RUN on the next clock.

Decomposition:
- Shared CPU package holds:
  - state encodings (RUN/CTRL_WAIT/REDIRECT/IO_WAIT), reused by debug/trace logic;
  - the default CTRL_TIMEOUT and FLUSH_CYCLES constants.
- One natural sub-module, stall_perf_counter: the PERF_W saturating counter with increment enable and async reset.
- The FSM and counter stay in the top block.

Test Plan:
- Reset mid-CTRL_WAIT: assert rst two cycles after PC_hazard -> immediately PC_write_en=0, IFID_flush=1, IDEX_flush=1; after release, state=0 and stall_cycles=0.
- Load-use: data_hazard high for 1 cycle in RUN -> that cycle PC_write_en=0, IFID_write_en=0, IDEX_flush=1; next cycle all enables 1; stall_cycles=1.
- Branch: PC_hazard at t0, PC_update at t3 -> t0..t2 PC_write_en=0 and IFID_flush=1; t3 PC_write_en=1; IFID_flush high t3..t4 (FLUSH_CYCLES=2); RUN at t5.
- Timeout: PC_hazard once, PC_update never -> ctrl_timeout rises after 7 CTRL_WAIT cycles; back in RUN; stays 1 until rst.
- Priority: keyboard_hazard, PC_hazard and data_hazard all high in RUN -> IO_WAIT with EXMEM_write_en=0 and no flushes; drop keyboard_hazard -> RUN.
- Saturation: force 65540 stall cycles (data_hazard held high) -> stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: stall FSM state encodings and default
// timing constants for the control-transfer wait and the redirect flush.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_CTRL_WAIT = 3'd1,
    ST_REDIRECT  = 3'd2,
    ST_IO_WAIT   = 3'd3
  } stall_state_e;

  localparam int DEF_CTRL_TIMEOUT = 7;
  localparam int DEF_FLUSH_CYCLES = 2;

endpackage

// File: rtl/pipeline_stall_ctrl_perf.sv
// Saturating stall-cycle performance counter; holds at all-ones instead of wrapping.
module stall_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc_en && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Consumer of the hazard requests: drives PC/IFID/IDEX/EXMEM enables and flushes
// and owns the control-transfer wait / redirect flush sequence.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CTRL_TIMEOUT = DEF_CTRL_TIMEOUT,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int CNT_W        = 3,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_hazard,
  input  logic              PC_hazard,
  input  logic              pop_haz,
  input  logic              keyboard_hazard,
  input  logic              PC_update,
  output logic              PC_write_en,
  output logic              IFID_write_en,
  output logic              IFID_flush,
  output logic              IDEX_flush,
  output logic              EXMEM_write_en,
  output logic              ctrl_timeout,
  output logic [2:0]        stall_state,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CTRL_TIMEOUT - 1);
  // A single-cycle flush is fully covered by the PC_update cycle itself.
  localparam stall_state_e AFTER_UPDATE = (FLUSH_CYCLES > 1) ? ST_REDIRECT : ST_RUN;

  stall_state_e     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
  logic             pc_we, ifid_we, ifid_fl, idex_fl, exmem_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_fl      = 1'b0;
    idex_fl      = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (keyboard_hazard) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          exmem_we   = 1'b0;
          state_next = ST_IO_WAIT;
        end else if (PC_update) begin
          ifid_fl    = 1'b1;
          cnt_next   = FLUSH_LOAD;
          state_next = AFTER_UPDATE;
        end else if (PC_hazard) begin
          pc_we      = 1'b0;
          ifid_fl    = 1'b1;
          cnt_next   = '0;
          state_next = ST_CTRL_WAIT;
        end else if (data_hazard || pop_haz) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_fl = 1'b1;
        end
      end

      ST_CTRL_WAIT: begin
        ifid_fl = 1'b1;
        if (PC_update) begin
          cnt_next   = FLUSH_LOAD;
          state_next = AFTER_UPDATE;
        end else begin
          pc_we    = 1'b0;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == TIMEOUT_LAST) begin
            timeout_next = 1'b1;
            state_next   = ST_RUN;
          end
        end
      end

      ST_REDIRECT: begin
        ifid_fl = 1'b1;
        if (PC_update) begin
          cnt_next   = FLUSH_LOAD;
          state_next = AFTER_UPDATE;
        end else begin
          cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = ST_RUN;
          end
        end
      end

      ST_IO_WAIT: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        exmem_we = 1'b0;
        if (!keyboard_hazard) begin
          state_next = ST_RUN;
        end
      end

      default: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        exmem_we   = 1'b0;
        cnt_next   = '0;
        state_next = ST_RUN;
      end
    endcase
  end

  // Reset forces the pipeline into a frozen, fully flushed condition.
  assign PC_write_en    = pc_we & ~rst;
  assign IFID_write_en  = ifid_we & ~rst;
  assign EXMEM_write_en = exmem_we & ~rst;
  assign IFID_flush     = ifid_fl | rst;
  assign IDEX_flush     = idex_fl | rst;
  assign ctrl_timeout   = timeout_reg;
  assign stall_state    = state_reg;

  stall_perf_counter #(
    .W(PERF_W)
  ) u_perf (
    .clk    (clk),
    .rst    (rst),
    .inc_en (~PC_write_en),
    .count  (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random
// hazard traffic compared cycle by cycle with a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int CTRL_TIMEOUT = 7;
  localparam int FLUSH_CYCLES = 2;
  localparam int PERF_W       = 16;
  localparam int PERF_MAX     = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst, data_hazard, PC_hazard, pop_haz, keyboard_hazard, PC_update;
  logic PC_write_en, IFID_write_en, IFID_flush, IDEX_flush, EXMEM_write_en, ctrl_timeout;
  logic [2:0]        stall_state;
  logic [PERF_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .CTRL_TIMEOUT(CTRL_TIMEOUT),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(3),
    .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst),
    .data_hazard(data_hazard), .PC_hazard(PC_hazard), .pop_haz(pop_haz),
    .keyboard_hazard(keyboard_hazard), .PC_update(PC_update),
    .PC_write_en(PC_write_en), .IFID_write_en(IFID_write_en),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .EXMEM_write_en(EXMEM_write_en), .ctrl_timeout(ctrl_timeout),
    .stall_state(stall_state), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode uses the documented state numbering (0 run, 1 waiting for target,
  // 2 flushing after redirect, 3 frozen for I/O).
  int m_mode = 0;
  int m_wait = 0;
  int m_flush_left = 0;
  bit m_timeout = 0;
  int m_stall = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic k, input logic u,
                      input logic h, input logic d, input logic p);
    logic e_pc, e_ifid, e_iff, e_idf, e_ex;
    int   e_state, e_stall, nxt;
    bit   e_to, redirect;
    @(negedge clk);
    rst = r; keyboard_hazard = k; PC_update = u; PC_hazard = h;
    data_hazard = d; pop_haz = p;
    #1;
    redirect = 1'b0;
    if (r) begin
      e_pc = 0; e_ifid = 0; e_ex = 0; e_iff = 1; e_idf = 1;
      e_state = 0; e_to = 0; e_stall = 0;
      m_mode = 0; m_wait = 0; m_flush_left = 0; m_timeout = 0; m_stall = 0;
    end else begin
      e_state = m_mode; e_to = m_timeout; e_stall = m_stall;
      nxt = m_mode;
      e_pc = 1; e_ifid = 1; e_ex = 1; e_iff = 0; e_idf = 0;
      if (m_mode == 0) begin
        if (k) begin
          e_pc = 0; e_ifid = 0; e_ex = 0; nxt = 3;
        end else if (u) begin
          e_iff = 1; redirect = 1'b1;
        end else if (h) begin
          e_pc = 0; e_iff = 1; m_wait = 0; nxt = 1;
        end else if (d || p) begin
          e_pc = 0; e_ifid = 0; e_idf = 1;
        end
      end else if (m_mode == 1) begin
        e_iff = 1;
        if (u) redirect = 1'b1;
        else begin
          e_pc = 0;
          m_wait++;
          if (m_wait == CTRL_TIMEOUT) begin
            m_timeout = 1; nxt = 0;
          end
        end
      end else if (m_mode == 2) begin
        e_iff = 1;
        if (u) redirect = 1'b1;
        else begin
          m_flush_left--;
          if (m_flush_left <= 0) nxt = 0;
        end
      end else begin
        e_pc = 0; e_ifid = 0; e_ex = 0;
        if (!k) nxt = 0;
      end
      if (redirect) begin
        m_flush_left = FLUSH_CYCLES - 1;
        nxt = (m_flush_left > 0) ? 2 : 0;
      end
      if (!e_pc && m_stall < PERF_MAX) m_stall++;
      m_mode = nxt;
    end
    check_val("PC_write_en", 32'(PC_write_en), 32'(e_pc));
    check_val("IFID_write_en", 32'(IFID_write_en), 32'(e_ifid));
    check_val("IFID_flush", 32'(IFID_flush), 32'(e_iff));
    check_val("IDEX_flush", 32'(IDEX_flush), 32'(e_idf));
    check_val("EXMEM_write_en", 32'(EXMEM_write_en), 32'(e_ex));
    check_val("stall_state", 32'(stall_state), 32'(e_state));
    check_val("ctrl_timeout", 32'(ctrl_timeout), 32'(e_to));
    check_val("stall_cycles", 32'(stall_cycles), 32'(e_stall));
  endtask

  initial begin
    rst = 1; data_hazard = 0; PC_hazard = 0; pop_haz = 0; keyboard_hazard = 0; PC_update = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Reset two cycles after PC_hazard, in the middle of the wait.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_val("rst_mid_wait_state", 32'(stall_state), 32'd0);
    $display("scenario reset_mid_ctrl_wait done: checks=%0d", checks);

    // Single load-use bubble.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check_val("loaduse_stall_cycles", 32'(stall_cycles), 32'd1);
    $display("scenario load_use done: checks=%0d", checks);

    // Branch resolved three cycles later.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check_val("branch_redirect_pc_we", 32'(PC_write_en), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check_val("branch_tail_flush", 32'(IFID_flush), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check_val("branch_back_to_run", 32'(stall_state), 32'd0);
    $display("scenario branch done: checks=%0d", checks);

    // Wait that never sees PC_update.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (CTRL_TIMEOUT + 1) step(0, 0, 0, 0, 0, 0);
    check_val("timeout_flag", 32'(ctrl_timeout), 32'd1);
    repeat (4) step(0, 0, 0, 0, 1, 0);
    check_val("timeout_sticky", 32'(ctrl_timeout), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check_val("timeout_cleared", 32'(ctrl_timeout), 32'd0);
    $display("scenario timeout done: checks=%0d", checks);

    // Keyboard freeze outranks control and data hazards.
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    check_val("priority_io_wait", 32'(stall_state), 32'd3);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_val("priority_exit_run", 32'(stall_state), 32'd0);
    $display("scenario priority done: checks=%0d", checks);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 64) == 0, ($urandom % 10) == 0, ($urandom % 5) == 0,
           ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0);
    end
    $display("scenario random done: checks=%0d", checks);

    // Saturation of the stall counter.
    step(1, 0, 0, 0, 0, 0);
    repeat (65540) step(0, 0, 0, 0, 1, 0);
    check_val("stall_saturated", 32'(stall_cycles), 32'h0000FFFF);
    $display("scenario saturation done: checks=%0d", checks);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
